// File: rtl/genesis_pad_reader_pkg.sv
// Shared constants for the Genesis 6-button pad reader: counter width default,
// button vector layout, synchroniser bus layout and the phase-update helper.
package genesis_pad_reader_pkg;

    localparam int CNT_W_DEF = 20;

    // Bit positions inside buttonsOut
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;
    localparam int NUM_BTNS  = 11;

    // Bit positions on the synchroniser bus: six data pins plus the select line
    localparam int PIN_UP_Z    = 0;
    localparam int PIN_DOWN_Y  = 1;
    localparam int PIN_LEFT_X  = 2;
    localparam int PIN_RIGHT   = 3;
    localparam int PIN_A_B     = 4;
    localparam int PIN_START_C = 5;
    localparam int PIN_SELECT  = 6;
    localparam int NUM_DATA    = 6;
    localparam int NUM_PINS    = 7;

    typedef enum logic {
        PHASE_DIR = 1'b0,   // pins carry Up/Down/Left/Right/A/Start
        PHASE_ALT = 1'b1    // pins carry Z/Y/X/Right/B/C
    } pad_phase_t;

    // Next button vector for one sample: only the buttons multiplexed onto the
    // current phase are refreshed, the others keep their last latched level.
    function automatic logic [NUM_BTNS-1:0] apply_phase(
        input logic [NUM_BTNS-1:0] cur,
        input logic [NUM_DATA-1:0] pins,
        input pad_phase_t          phase
    );
        logic [NUM_BTNS-1:0] nxt;
        nxt = cur;
        nxt[BTN_RIGHT] = pins[PIN_RIGHT];
        if (phase == PHASE_DIR) begin
            nxt[BTN_UP]    = pins[PIN_UP_Z];
            nxt[BTN_DOWN]  = pins[PIN_DOWN_Y];
            nxt[BTN_LEFT]  = pins[PIN_LEFT_X];
            nxt[BTN_A]     = pins[PIN_A_B];
            nxt[BTN_START] = pins[PIN_START_C];
        end else begin
            nxt[BTN_Z]     = pins[PIN_UP_Z];
            nxt[BTN_Y]     = pins[PIN_DOWN_Y];
            nxt[BTN_X]     = pins[PIN_LEFT_X];
            nxt[BTN_B]     = pins[PIN_A_B];
            nxt[BTN_C]     = pins[PIN_START_C];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/genesis_pad_reader_pad_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous pad lines.
module pad_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/genesis_pad_reader.sv
// Genesis 6-button pad reader: synchronises the pad lines and latches them
// into an 11-bit button vector once per 2**CNT_W-clock sample period.
module genesis_pad_reader
    import genesis_pad_reader_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clock_50,
    input  logic                reset_key,
    input  logic                up_z,
    input  logic                down_y,
    input  logic                left_x,
    input  logic                right,
    input  logic                a_b,
    input  logic                selectSignal,
    input  logic                start_c,
    output logic [NUM_BTNS-1:0] buttonsOut
);

    logic [NUM_PINS-1:0] w_pins_raw;
    logic [NUM_PINS-1:0] w_pins_sync;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_tick;
    pad_phase_t          w_phase;
    logic [NUM_BTNS-1:0] w_buttons_next;
    logic [NUM_BTNS-1:0] r_buttons;

    // Select travels through the same synchroniser as the data pins so that a
    // phase change and the data it qualifies arrive together.
    always_comb begin
        w_pins_raw              = '0;
        w_pins_raw[PIN_UP_Z]    = up_z;
        w_pins_raw[PIN_DOWN_Y]  = down_y;
        w_pins_raw[PIN_LEFT_X]  = left_x;
        w_pins_raw[PIN_RIGHT]   = right;
        w_pins_raw[PIN_A_B]     = a_b;
        w_pins_raw[PIN_START_C] = start_c;
        w_pins_raw[PIN_SELECT]  = selectSignal;
    end

    pad_sync #(
        .WIDTH (NUM_PINS)
    ) u_pad_sync (
        .clk   (clock_50),
        .rst_n (reset_key),
        .d     (w_pins_raw),
        .q     (w_pins_sync)
    );

    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign w_tick  = &r_cnt;
    assign w_phase = pad_phase_t'(w_pins_sync[PIN_SELECT]);

    assign w_buttons_next = apply_phase(r_buttons,
                                        w_pins_sync[PIN_START_C:PIN_UP_Z],
                                        w_phase);

    // Sampling only on the tick is what debounces the contacts.
    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            r_buttons <= '0;
        end else if (w_tick) begin
            r_buttons <= w_buttons_next;
        end
    end

    assign buttonsOut = r_buttons;

endmodule

// File: tb/tb_genesis_pad_reader.sv
// Scoreboard bench for genesis_pad_reader with a 16-clock sample period.
module tb_genesis_pad_reader;

    localparam int CNT_W = 4;

    logic        clock_50 = 1'b0;
    logic        reset_key = 1'b0;
    logic        up_z = 1'b0, down_y = 1'b0, left_x = 1'b0, right = 1'b0;
    logic        a_b = 1'b0, selectSignal = 1'b0, start_c = 1'b0;
    logic [10:0] buttonsOut;

    genesis_pad_reader #(.CNT_W(CNT_W)) dut (
        .clock_50     (clock_50),
        .reset_key    (reset_key),
        .up_z         (up_z),
        .down_y       (down_y),
        .left_x       (left_x),
        .right        (right),
        .a_b          (a_b),
        .selectSignal (selectSignal),
        .start_c      (start_c),
        .buttonsOut   (buttonsOut)
    );

    always #10 clock_50 = ~clock_50;

    typedef struct {
        int          edge_no;
        logic [10:0] value;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_item;
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;   // rising edges since reset release

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int e, input logic [10:0] v);
        sb_q.push_back('{e, v});
    endtask

    task automatic wait_edge(input int n);
        int guard;
        guard = 0;
        while (edge_cnt < n && guard < 500) begin
            @(negedge clock_50);
            guard++;
        end
        if (edge_cnt < n) check_eq("timeout", edge_cnt, n);
    endtask

    // p = {start_c, a_b, right, left_x, down_y, up_z}
    task automatic set_pins(input logic sel, input logic [5:0] p);
        selectSignal = sel;
        up_z    = p[0];
        down_y  = p[1];
        left_x  = p[2];
        right   = p[3];
        a_b     = p[4];
        start_c = p[5];
    endtask

    // Output monitor: compares buttonsOut #1 after each scheduled edge.
    always @(posedge clock_50) begin
        if (!reset_key) begin
            edge_cnt = 0;
        end else begin
            edge_cnt = edge_cnt + 1;
            #1;
            while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
                sb_item = sb_q.pop_front();
                if (sb_item.edge_no != edge_cnt) begin
                    check_eq("sb_missed_edge", edge_cnt, sb_item.edge_no);
                end else begin
                    $display("edge %0d buttonsOut=0x%03h expected=0x%03h",
                             edge_cnt, buttonsOut, sb_item.value);
                    check_eq($sformatf("edge%0d", edge_cnt), buttonsOut, sb_item.value);
                end
            end
        end
    end

    initial begin
        // Pins toggling while reset is held must not reach the output
        for (int i = 0; i < 8; i++) begin
            @(negedge clock_50);
            set_pins(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
            check_eq("rst_hold", buttonsOut, 11'h000);
        end

        // Release with Right bouncing 1/0/1, then held
        @(negedge clock_50);
        set_pins(1'b0, 6'b001000);
        reset_key = 1'b1;
        push_exp(8, 11'h000);
        push_exp(15, 11'h000);
        push_exp(16, 11'h008);
        wait_edge(1);
        right = 1'b0;
        wait_edge(2);
        right = 1'b1;

        // Phase 0: Up, A, Start pressed, Right released
        wait_edge(16);
        set_pins(1'b0, 6'b110001);
        push_exp(24, 11'h008);
        push_exp(31, 11'h008);
        push_exp(32, 11'h091);

        // Phase 1: Z, Y, X, B, C pressed; Up/A/Start must hold
        wait_edge(32);
        set_pins(1'b1, 6'b110111);
        push_exp(47, 11'h091);
        push_exp(48, 11'h7F1);

        // Short Left pulse between ticks is never latched
        wait_edge(48);
        set_pins(1'b0, 6'b110001);
        push_exp(52, 11'h7F1);
        push_exp(56, 11'h7F1);
        push_exp(60, 11'h7F1);
        push_exp(64, 11'h7F1);
        wait_edge(51);
        left_x = 1'b1;
        wait_edge(55);
        left_x = 1'b0;

        // Phase 1 with Right pressed, then a change two edges before the tick
        // that is too late for that tick but taken by the next one
        wait_edge(64);
        set_pins(1'b1, 6'b111111);
        push_exp(79, 11'h7F1);
        push_exp(80, 11'h7F9);
        push_exp(95, 11'h7F9);
        push_exp(96, 11'h760);
        wait_edge(78);
        set_pins(1'b0, 6'b000000);

        // Reset mid-period clears the output without waiting for a clock
        wait_edge(100);
        check_eq("sb_drain1", sb_q.size(), 0);
        check_eq("pre_reset", buttonsOut, 11'h760);
        reset_key = 1'b0;
        #1;
        check_eq("rst_async", buttonsOut, 11'h000);
        set_pins(1'b0, 6'b001000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_50);
            check_eq("rst_held", buttonsOut, 11'h000);
        end

        // Next update a full period after release
        reset_key = 1'b1;
        push_exp(8, 11'h000);
        push_exp(15, 11'h000);
        push_exp(16, 11'h008);
        wait_edge(20);
        check_eq("sb_drain2", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
